mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port synchronous block RAM between the CPU and one I/O master (VGA/DMA-style).
//  Sits between the CPU memory interface (mem_addr, writedata, MEM_WR_S) and the RAM.
//  The CPU has priority. A wait counter guarantees the I/O master is served. I/O bursts are supported through a capped bus lock.
// PARAMETERS
//  WIDTH     16  data width
//  ADDR_W    16  address width
//  MAX_WAIT  4   consecutive denied I/O-request cycles before I/O is forced to win
//  LOCK_MAX  8   maximum cycles I/O may hold the bus in one locked burst
// PORTS
//  clk         in   1       system clock
//  reset       in   1       asynchronous, active-low reset
//  cpu_req     in   1       CPU access request; held until cpu_gnt
//  cpu_we      in   1       CPU write (1) / read (0)
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   WIDTH   CPU write data
//  cpu_gnt     out  1       CPU access issued to RAM this cycle
//  cpu_rvalid  out  1       cpu_rdata valid (read issued previous cycle)
//  cpu_rdata   out  WIDTH   read data to CPU
//  io_req, io_we, io_addr, io_wdata   in   same as CPU side
//  io_lock     in   1       keep the bus after the current I/O grant (burst)
//  io_gnt, io_rvalid, io_rdata        out  same as CPU side
//  mem_we      out  1       RAM write enable
//  mem_addr    out  ADDR_W  RAM address
//  mem_wdata   out  WIDTH   RAM write data
//  mem_rdata   in   WIDTH   RAM read data, valid one cycle after the address
// BEHAVIOUR
//  - Reset (reset=0, async): state=ARB; wait_cnt=0; lock_cnt=0; rd_owner=NONE.
//    All gnt, rvalid and mem_we outputs are 0. mem_addr=0, mem_wdata=0, both rdata=0.
//  - Grant is combinational from the current requests and the registered state. At most one gnt per cycle.
//    The mem_* outputs mux the winner's we/addr/wdata. With no winner, mem_we=0 and addr/wdata hold 0.
//  - State ARB:
//    * cpu_req && !(io_req && wait_cnt==MAX_WAIT) -> CPU wins.
//    * else io_req -> I/O wins.
//    * else idle.
//  - wait_cnt:
//    * increments on cycles where io_req=1 and I/O is not granted; saturates at MAX_WAIT.
//    * clears on any io_gnt or when io_req=0.
//  - I/O granted in ARB with io_lock=1 -> next state IO_LOCK, lock_cnt=1.
//  - State IO_LOCK:
//    * I/O always wins when io_req=1; CPU is denied.
//    * lock_cnt increments per cycle.
//    * Return to ARB when io_lock=0, io_req=0, or lock_cnt==LOCK_MAX (forced release).
//      The forced-release cycle still serves the I/O request, if present.
//    * Next ARB cycle after a forced release: CPU wins if it is requesting.
//  - Read return: 1-cycle latency.
//    * rd_owner registers the winner of a read (we=0).
//    * Next cycle: <owner>_rvalid=1 and <owner>_rdata=mem_rdata. The other rdata holds its last value.
//    * Writes produce no rvalid.
//    * Back-to-back reads by alternating owners each return correctly in the following cycle.
//  - Simultaneous cpu_req & io_req with wait_cnt<MAX_WAIT: CPU wins and wait_cnt increments.
//  - Request dropped before grant: no access, no rvalid.
//  - Reset mid-read: the pending rvalid is discarded.
//  - Reset during IO_LOCK: return to ARB.
// STRUCTURE
//  - Shared package: state encoding (ST_ARB, ST_IO_LOCK) and owner codes (OWN_NONE, OWN_CPU, OWN_IO).
//  - One sub-module: arb_wait_counter (saturating counter: inc/clr/sat flag), used for wait_cnt and lock_cnt.
//  - Everything else (FSM, grant logic, muxes, rd_owner register) stays in mem_arbiter.
// TESTING
//  1. CPU alone reads addr 0x0010 with RAM value 0xBEEF.
//     -> cpu_gnt same cycle, mem_addr=0x0010; next cycle cpu_rvalid=1, cpu_rdata=0xBEEF.
//  2. cpu_req and io_req held high continuously (MAX_WAIT=4).
//     -> CPU granted 4 cycles, I/O granted cycle 5, wait_cnt returns to 0; pattern repeats.
//  3. I/O write 0x1234 to 0x0200 with io_lock=1 held and cpu_req=1.
//     -> 8 consecutive io_gnt (lock_cnt reaches LOCK_MAX), then cpu_gnt on the next cycle.
//  4. Alternating reads: CPU @0x0001, then I/O @0x0002.
//     -> cpu_rvalid cycle+1, io_rvalid cycle+2; each gets its own mem_rdata, no cross-delivery.
//  5. reset asserted in the cycle after a CPU read grant, while in IO_LOCK.
//     -> all outputs 0 immediately (asynchronous); no cpu_rvalid; state ARB after release.
//  6. CPU write 0x00FF -> mem_we=1, mem_wdata=0x00FF for exactly one cycle, no rvalid.
//     Checker: gnt outputs are never both 1 in the same cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the CPU / I/O block-RAM arbiter.
package mem_arbiter_pkg;

    typedef enum logic {
        ST_ARB,
        ST_IO_LOCK
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_IO
    } owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module arb_wait_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign cnt = cnt_q;
    assign sat = (cnt_q == W'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port RAM between the CPU (priority) and an I/O master
// with starvation guard and capped I/O burst lock.
//   state      | meaning
//   ST_ARB     | normal arbitration, CPU first unless I/O has waited MAX_WAIT cycles
//   ST_IO_LOCK | I/O burst owns the bus, CPU denied until release or LOCK_MAX grants
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WIDTH-1:0]  cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [WIDTH-1:0]  cpu_rdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [WIDTH-1:0]  io_wdata,
    input  logic              io_lock,
    output logic              io_gnt,
    output logic              io_rvalid,
    output logic [WIDTH-1:0]  io_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int LOCK_W = $clog2(LOCK_MAX + 1);

    arb_state_e        state_q, state_d;
    owner_e            rd_owner_q, rd_owner_d;
    logic [WIDTH-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic [WIDTH-1:0]  io_rdata_q, io_rdata_d;

    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_sat, wait_inc, wait_clr;
    logic [LOCK_W-1:0] lock_cnt;
    logic              lock_sat, lock_inc, lock_clr, lock_release;
    logic              io_force;

    arb_wait_counter #(.MAX(MAX_WAIT), .W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .cnt   (wait_cnt),
        .sat   (wait_sat)
    );

    arb_wait_counter #(.MAX(LOCK_MAX), .W(LOCK_W)) u_lock_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lock_inc),
        .clr   (lock_clr),
        .cnt   (lock_cnt),
        .sat   (lock_sat)
    );

    assign io_force = io_req && (wait_cnt == WAIT_W'(MAX_WAIT));

    // Grants are gated by reset so the bus goes quiet the instant reset asserts.
    always_comb begin
        cpu_gnt = 1'b0;
        io_gnt  = 1'b0;
        if (reset) begin
            if (state_q == ST_IO_LOCK) begin
                io_gnt = io_req;
            end else if (cpu_req && !io_force) begin
                cpu_gnt = 1'b1;
            end else if (io_req) begin
                io_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (io_gnt) begin
            mem_we    = io_we;
            mem_addr  = io_addr;
            mem_wdata = io_wdata;
        end
    end

    assign wait_inc = io_req && !io_gnt && !wait_sat;
    assign wait_clr = io_gnt || !io_req;

    // lock_cnt counts burst grants; the grant that brings it to LOCK_MAX is the last one.
    assign lock_release = !io_lock || !io_req || lock_sat
                          || (lock_cnt == LOCK_W'(LOCK_MAX - 1));
    assign lock_inc     = (state_q == ST_ARB) ? (io_gnt && io_lock) : !lock_release;
    assign lock_clr     = (state_q == ST_IO_LOCK) && lock_release;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:     if (io_gnt && io_lock) state_d = ST_IO_LOCK;
            ST_IO_LOCK: if (lock_release)      state_d = ST_ARB;
            default:                           state_d = ST_ARB;
        endcase
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (cpu_gnt && !cpu_we) begin
            rd_owner_d = OWN_CPU;
        end else if (io_gnt && !io_we) begin
            rd_owner_d = OWN_IO;
        end
    end

    // Read data passes straight from the RAM in the return cycle, then is held.
    assign cpu_rvalid  = (rd_owner_q == OWN_CPU);
    assign io_rvalid   = (rd_owner_q == OWN_IO);
    assign cpu_rdata_d = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign io_rdata_d  = io_rvalid  ? mem_rdata : io_rdata_q;
    assign cpu_rdata   = cpu_rdata_d;
    assign io_rdata    = io_rdata_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_ARB;
            rd_owner_q  <= OWN_NONE;
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_owner_q  <= rd_owner_d;
            cpu_rdata_q <= cpu_rdata_d;
            io_rdata_q  <= io_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small synchronous RAM model.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        io_req, io_we, io_lock;
    logic [15:0] io_addr, io_wdata;
    logic        io_gnt, io_rvalid;
    logic [15:0] io_rdata;
    logic        mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic [15:0] ram [0:1023];

    int tests;
    int fails;

    logic [7:0] drop_io_req;
    logic [7:0] drop_exp_io;

    mem_arbiter #(.WIDTH(16), .ADDR_W(16), .MAX_WAIT(4), .LOCK_MAX(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .io_req     (io_req),
        .io_we      (io_we),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_lock    (io_lock),
        .io_gnt     (io_gnt),
        .io_rvalid  (io_rvalid),
        .io_rdata   (io_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[9:0]];
    end

    always @(negedge clk) begin
        tests++;
        if (cpu_gnt && io_gnt) begin
            fails++;
            $display("FAIL gnt_exclusive: cpu_gnt=%b io_gnt=%b both high at %0t", cpu_gnt, io_gnt, $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        io_req = 0; io_we = 0; io_addr = 16'h0; io_wdata = 16'h0; io_lock = 0;
    endtask

    task automatic test_reset();
        cpu_req = 1; cpu_addr = 16'h0010; io_req = 1; io_addr = 16'h0020;
        #2;
        tests++;
        if ({cpu_gnt, io_gnt, mem_we, cpu_rvalid, io_rvalid} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_ctrl: got gnt/we/rvalid=%b want 00000",
                     {cpu_gnt, io_gnt, mem_we, cpu_rvalid, io_rvalid});
        end
        tests++;
        if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || cpu_rdata !== 16'h0 || io_rdata !== 16'h0) begin
            fails++;
            $display("FAIL reset_data: got addr=%h wdata=%h crd=%h ird=%h want all 0",
                     mem_addr, mem_wdata, cpu_rdata, io_rdata);
        end
        @(negedge clk);
        reset = 1;
        clear_inputs();
    endtask

    task automatic test_cpu_read();
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        @(negedge clk);
        tests++;
        if ({cpu_gnt, io_gnt, mem_we} !== 3'b100 || mem_addr !== 16'h0010) begin
            fails++;
            $display("FAIL cpu_read_gnt: got gnt/io/we=%b addr=%h want 100 addr=0010",
                     {cpu_gnt, io_gnt, mem_we}, mem_addr);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        tests++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBEEF || io_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL cpu_read_data: got rvalid=%b rdata=%h io_rvalid=%b want 1 BEEF 0",
                     cpu_rvalid, cpu_rdata, io_rvalid);
        end
        tick();
        @(negedge clk);
        tests++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'hBEEF) begin
            fails++;
            $display("FAIL cpu_read_hold: got rvalid=%b rdata=%h want 0 BEEF", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_contention();
        logic exp_io;
        tick();
        cpu_req = 1; cpu_addr = 16'h0040; io_req = 1; io_addr = 16'h0041;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            exp_io = (i % 5 == 0);
            tests++;
            if ({cpu_gnt, io_gnt} !== {!exp_io, exp_io}) begin
                fails++;
                $display("FAIL contention_c%0d: got cpu/io=%b want %b", i, {cpu_gnt, io_gnt}, {!exp_io, exp_io});
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_drop();
        logic exp_io;
        drop_io_req = 8'b1111_1011;
        drop_exp_io = 8'b1000_0000;
        tick();
        cpu_req = 1; cpu_addr = 16'h0042; io_addr = 16'h0043;
        for (int i = 0; i < 8; i++) begin
            io_req = drop_io_req[i];
            exp_io = drop_exp_io[i];
            @(negedge clk);
            tests++;
            if ({cpu_gnt, io_gnt, io_rvalid} !== {!exp_io, exp_io, 1'b0}) begin
                fails++;
                $display("FAIL drop_c%0d: got cpu/io/io_rvalid=%b want %b", i,
                         {cpu_gnt, io_gnt, io_rvalid}, {!exp_io, exp_io, 1'b0});
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_lock_burst();
        logic exp_io;
        tick();
        cpu_req = 1; cpu_addr = 16'h0050;
        io_req = 1; io_we = 1; io_addr = 16'h0200; io_wdata = 16'h1234; io_lock = 1;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            exp_io = (i >= 5) && (i <= 12);
            tests++;
            if ({cpu_gnt, io_gnt} !== {!exp_io, exp_io}) begin
                fails++;
                $display("FAIL lock_c%0d: got cpu/io=%b want %b", i, {cpu_gnt, io_gnt}, {!exp_io, exp_io});
            end
            if (exp_io) begin
                tests++;
                if (mem_we !== 1'b1 || mem_addr !== 16'h0200 || mem_wdata !== 16'h1234) begin
                    fails++;
                    $display("FAIL lock_bus_c%0d: got we=%b addr=%h wdata=%h want 1 0200 1234",
                             i, mem_we, mem_addr, mem_wdata);
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_alt_reads();
        tick();
        cpu_req = 1; cpu_addr = 16'h0001;
        @(negedge clk);
        tests++;
        if ({cpu_gnt, io_gnt} !== 2'b10 || mem_addr !== 16'h0001) begin
            fails++;
            $display("FAIL alt_c1: got cpu/io=%b addr=%h want 10 0001", {cpu_gnt, io_gnt}, mem_addr);
        end
        tick();
        clear_inputs();
        io_req = 1; io_addr = 16'h0002;
        @(negedge clk);
        tests++;
        if ({io_gnt, cpu_rvalid, io_rvalid} !== 3'b110 || cpu_rdata !== 16'h1111 || mem_addr !== 16'h0002) begin
            fails++;
            $display("FAIL alt_c2: got io_gnt/crv/irv=%b crd=%h addr=%h want 110 1111 0002",
                     {io_gnt, cpu_rvalid, io_rvalid}, cpu_rdata, mem_addr);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        tests++;
        if ({cpu_rvalid, io_rvalid} !== 2'b01 || io_rdata !== 16'h2222 || cpu_rdata !== 16'h1111) begin
            fails++;
            $display("FAIL alt_c3: got crv/irv=%b ird=%h crd=%h want 01 2222 1111",
                     {cpu_rvalid, io_rvalid}, io_rdata, cpu_rdata);
        end
    endtask

    task automatic test_reset_midread();
        tick();
        cpu_req = 1; cpu_addr = 16'h0010;
        @(negedge clk);
        tick();
        cpu_req = 0;
        reset = 0;
        #1;
        tests++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'h0 || cpu_gnt !== 1'b0) begin
            fails++;
            $display("FAIL rst_midread: got rvalid=%b rdata=%h gnt=%b want 0 0000 0", cpu_rvalid, cpu_rdata, cpu_gnt);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        tests++;
        if (cpu_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_rvalid: got cpu_rvalid=%b want 0", cpu_rvalid);
        end
        tick();
        io_req = 1; io_lock = 1; io_addr = 16'h0002;
        @(negedge clk);
        tests++;
        if ({cpu_gnt, io_gnt} !== 2'b01) begin
            fails++;
            $display("FAIL rst_lock_enter: got cpu/io=%b want 01", {cpu_gnt, io_gnt});
        end
        tick();
        cpu_req = 1;
        @(negedge clk);
        tests++;
        if ({cpu_gnt, io_gnt} !== 2'b01) begin
            fails++;
            $display("FAIL rst_lock_hold: got cpu/io=%b want 01", {cpu_gnt, io_gnt});
        end
        tick();
        reset = 0;
        #1;
        tests++;
        if ({cpu_gnt, io_gnt, mem_we, cpu_rvalid, io_rvalid} !== 5'b00000 || mem_addr !== 16'h0) begin
            fails++;
            $display("FAIL rst_in_lock: got gnt/we/rvalid=%b addr=%h want 00000 0000",
                     {cpu_gnt, io_gnt, mem_we, cpu_rvalid, io_rvalid}, mem_addr);
        end
        @(negedge clk);
        reset = 1;
        #1;
        tests++;
        if ({cpu_gnt, io_gnt} !== 2'b10) begin
            fails++;
            $display("FAIL rst_back_to_arb: got cpu/io=%b want 10", {cpu_gnt, io_gnt});
        end
    endtask

    task automatic test_cpu_write();
        tick();
        clear_inputs();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 16'h00FF;
        @(negedge clk);
        tests++;
        if ({cpu_gnt, io_gnt, mem_we} !== 3'b101 || mem_wdata !== 16'h00FF || mem_addr !== 16'h0030) begin
            fails++;
            $display("FAIL write_issue: got gnt/io/we=%b wdata=%h addr=%h want 101 00FF 0030",
                     {cpu_gnt, io_gnt, mem_we}, mem_wdata, mem_addr);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        tests++;
        if (mem_we !== 1'b0 || mem_wdata !== 16'h0 || cpu_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL write_once: got we=%b wdata=%h rvalid=%b want 0 0000 0", mem_we, mem_wdata, cpu_rvalid);
        end
        tick();
        cpu_req = 1; cpu_addr = 16'h0030;
        @(negedge clk);
        tick();
        clear_inputs();
        @(negedge clk);
        tests++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h00FF) begin
            fails++;
            $display("FAIL write_readback: got rvalid=%b rdata=%h want 1 00FF", cpu_rvalid, cpu_rdata);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 0;
        clear_inputs();
        for (int i = 0; i < 1024; i++) ram[i] = 16'h0;
        ram[16'h0010] = 16'hBEEF;
        ram[16'h0001] = 16'h1111;
        ram[16'h0002] = 16'h2222;
        mem_rdata = 16'h0;

        test_reset();
        test_cpu_read();
        test_contention();
        test_drop();
        test_lock_burst();
        test_alt_reads();
        test_reset_midread();
        test_cpu_write();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
